alu_wide_sequencer: RTL and testbench

Multi-cycle command initiator that drives an external combinational ALU (the 4-bit `G_sel` / 32-bit `A`, `B` / `G` / `ZCNVFlags` interface) and returns registered results over a valid/ready handshake. It executes 32-bit operations in one ALU pass. It executes 64-bit add, subtract and logic operations in two or three passes, chaining carry/borrow through a correction pass because the ALU has no carry-in port. It sits between the instruction-issue logic and the ALU instance.

---
 rtl/alu_wide_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_wide_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_wide_sequencer
// Description : Command initiator for an external 32-bit combinational ALU.
//               32-bit operations take one ALU pass. 64-bit ADD/SUB/logic
//               operations take two passes, plus a third pass that adds or
//               subtracts the carry/borrow from the low half, because the
//               ALU has no carry-in. Results return over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [3:0]  alu_G_sel,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    input  logic [31:0] alu_G,
    input  logic [3:0]  alu_flags
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_XOR = 4'b1000;
    localparam logic [3:0] c_OP_OR  = 4'b1100;
    localparam logic [3:0] c_OP_AND = 4'b1110;

    // Bit positions inside the ALU / response flag nibble
    localparam int c_FLAG_C = 2;
    localparam int c_FLAG_V = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    logic [3:0]  op_q,     op_d;
    logic        wide_q,   wide_d;
    logic [63:0] a_q,      a_d;
    logic [63:0] b_q,      b_d;
    logic [63:0] result_q, result_d;
    logic        c_lo_q,   c_lo_d;
    logic        c_hi_q,   c_hi_d;
    logic        v_hi_q,   v_hi_d;
    logic [3:0]  flags_q,  flags_d;
    logic        err_q,    err_d;

    logic        w_req_legal;
    logic        w_arith;
    logic        w_need_fix;
    logic        w_fix_c;
    logic        w_alu_c;
    logic        w_alu_v;

    // ALU Z and N are recomputed locally from the assembled result
    logic        w_unused_alu_zn;
    assign w_unused_alu_zn = alu_flags[3] ^ alu_flags[1];

    assign w_alu_c = alu_flags[c_FLAG_C];
    assign w_alu_v = alu_flags[c_FLAG_V];

    assign w_req_legal = (req_op == c_OP_ADD) || (req_op == c_OP_SUB) ||
                         (req_op == c_OP_XOR) || (req_op == c_OP_OR)  ||
                         (req_op == c_OP_AND);

    assign w_arith = (op_q == c_OP_ADD) || (op_q == c_OP_SUB);

    // The low-half carry (ADD) or borrow (SUB) must be folded into the high half
    assign w_need_fix = ((op_q == c_OP_ADD) &&  c_lo_q) ||
                        ((op_q == c_OP_SUB) && !c_lo_q);

    // ADD: carry out of either high pass. SUB: no borrow from either pass.
    assign w_fix_c = (op_q == c_OP_ADD) ? (c_hi_q | w_alu_c) : (c_hi_q & w_alu_c);

    // Assemble {Z,C,N,V}; logic ops never report carry or overflow
    function automatic logic [3:0] f_flags(
        input logic        wide,
        input logic [63:0] res,
        input logic        arith,
        input logic        c,
        input logic        v
    );
        logic z;
        logic n;
        z = wide ? (res == 64'd0) : (res[31:0] == 32'd0);
        n = wide ? res[63] : res[31];
        return {z, c & arith, n, v & arith};
    endfunction

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;

    // Next-state, ALU drive and capture of each pass result
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wide_d    = wide_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        c_lo_d    = c_lo_q;
        c_hi_d    = c_hi_q;
        v_hi_d    = v_hi_q;
        flags_d   = flags_q;
        err_d     = err_q;
        alu_G_sel = 4'b0000;
        alu_A     = 32'd0;
        alu_B     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d     = req_op;
                    wide_d   = req_wide;
                    a_d      = req_a;
                    b_d      = req_b;
                    result_d = 64'd0;
                    flags_d  = 4'd0;
                    c_lo_d   = 1'b0;
                    c_hi_d   = 1'b0;
                    v_hi_d   = 1'b0;
                    err_d    = !w_req_legal;
                    state_d  = w_req_legal ? S_LO : S_DONE;
                end
            end

            S_LO: begin
                alu_G_sel      = op_q;
                alu_A          = a_q[31:0];
                alu_B          = b_q[31:0];
                result_d[31:0] = alu_G;
                c_lo_d         = w_alu_c;
                if (wide_q) begin
                    state_d = S_HI;
                end else begin
                    flags_d = f_flags(1'b0, {32'd0, alu_G}, w_arith, w_alu_c, w_alu_v);
                    state_d = S_DONE;
                end
            end

            S_HI: begin
                alu_G_sel       = op_q;
                alu_A           = a_q[63:32];
                alu_B           = b_q[63:32];
                result_d[63:32] = alu_G;
                c_hi_d          = w_alu_c;
                v_hi_d          = w_alu_v;
                if (w_need_fix) begin
                    state_d = S_FIX;
                end else begin
                    flags_d = f_flags(1'b1, {alu_G, result_q[31:0]}, w_arith, w_alu_c, w_alu_v);
                    state_d = S_DONE;
                end
            end

            S_FIX: begin
                alu_G_sel       = op_q;
                alu_A           = result_q[63:32];
                alu_B           = 32'd1;
                result_d[63:32] = alu_G;
                flags_d = f_flags(1'b1, {alu_G, result_q[31:0]}, 1'b1, w_fix_c, v_hi_q ^ w_alu_v);
                state_d = S_DONE;
            end

            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            wide_q   <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            result_q <= 64'd0;
            c_lo_q   <= 1'b0;
            c_hi_q   <= 1'b0;
            v_hi_q   <= 1'b0;
            flags_q  <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wide_q   <= wide_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            c_lo_q   <= c_lo_d;
            c_hi_q   <= c_hi_d;
            v_hi_q   <= v_hi_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wide_sequencer
// Description : Bench for alu_wide_sequencer with an ALU model, a per-cycle
//               behavioural reference and directed literal cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wide_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [3:0]  alu_G_sel;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [31:0] alu_G;
    logic [3:0]  alu_flags;

    int n_checks = 0;
    int n_errors = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    alu_wide_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_wide   (req_wide),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_G_sel  (alu_G_sel),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_G      (alu_G),
        .alu_flags  (alu_flags)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // External ALU. Z/N are deliberately wrong and logic ops report C=V=1,
    // since the sequencer must not depend on either.
    function automatic logic [35:0] alu_model(input logic [3:0] sel, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] g;
        logic        c;
        logic        v;
        s = 33'd0;
        g = 32'd0;
        c = 1'b1;
        v = 1'b1;
        case (sel)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, b};
                g = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (g[31] != a[31]);
            end
            4'b0001: begin
                g = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (g[31] != a[31]);
            end
            4'b1000: g = a ^ b;
            4'b1100: g = a | b;
            4'b1110: g = a & b;
            default: g = 32'hDEAD_BEEF;
        endcase
        return {(g != 32'd0), c, ~g[31], v, g};
    endfunction

    always_comb {alu_flags, alu_G} = alu_model(alu_G_sel, alu_A, alu_B);

    typedef struct packed {
        logic        err;
        logic [63:0] res;
        logic [3:0]  flags;
        logic [2:0]  lat;
    } exp_t;

    // Expected response from whole-word arithmetic
    function automatic exp_t ref_model(input logic [3:0] op, input logic wide,
                                       input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [64:0] s;
        logic [32:0] t;
        logic        c;
        logic        v;
        logic        fix;
        logic        msb;
        e   = '0;
        c   = 1'b0;
        v   = 1'b0;
        fix = 1'b0;
        if (!(op == 4'b0000 || op == 4'b0001 || op == 4'b1000 || op == 4'b1100 || op == 4'b1110)) begin
            e.err = 1'b1;
            e.lat = 3'd1;
            return e;
        end
        if (!wide) begin
            a[63:32] = 32'd0;
            b[63:32] = 32'd0;
        end
        case (op)
            4'b0000: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[63:0];
                t     = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                fix   = t[32];
                if (wide) begin
                    c = s[64];
                    v = (a[63] == b[63]) && (e.res[63] != a[63]);
                end else begin
                    c = t[32];
                    v = (a[31] == b[31]) && (e.res[31] != a[31]);
                    e.res[63:32] = 32'd0;
                end
            end
            4'b0001: begin
                e.res = a - b;
                fix   = a[31:0] < b[31:0];
                if (wide) begin
                    c = (a >= b);
                    v = (a[63] != b[63]) && (e.res[63] != a[63]);
                end else begin
                    c = (a[31:0] >= b[31:0]);
                    v = (a[31] != b[31]) && (e.res[31] != a[31]);
                    e.res[63:32] = 32'd0;
                end
            end
            4'b1000: e.res = a ^ b;
            4'b1100: e.res = a | b;
            default: e.res = a & b;
        endcase
        msb = wide ? e.res[63] : e.res[31];
        e.flags = {(e.res == 64'd0), c, msb, v};
        e.lat   = wide ? (3'd3 + {2'd0, fix}) : 3'd2;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare against the reference
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mstate_t;
    mstate_t     m_state = M_IDLE;
    logic        m_clear = 1'b1;
    exp_t        m_exp;
    logic [3:0]  m_op;
    logic [63:0] m_a;
    logic [63:0] m_b;
    int          m_pass;

    function automatic logic [63:0] pass_drive(input int p, input logic [3:0] op,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0] hr;
        hr = (op == 4'b0000) ? (a[63:32] + b[63:32]) : (a[63:32] - b[63:32]);
        if (p == 1) return {a[31:0], b[31:0]};
        if (p == 2) return b[63:32] | (64'(a[63:32]) << 32);
        return {hr, 32'd1};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            case (m_state)
                M_IDLE: begin
                    chk("idle_req_ready", req_ready, !reset);
                    chk("idle_rsp_valid", rsp_valid, 1'b0);
                    chk("idle_alu_sel", alu_G_sel, 4'd0);
                    chk("idle_alu_ab", {alu_A, alu_B}, 64'd0);
                    if (m_clear) begin
                        chk("cleared_result", rsp_result, 64'd0);
                        chk("cleared_flags_err", {rsp_flags, rsp_err}, 5'd0);
                    end
                end
                M_BUSY: begin
                    chk("busy_req_ready", req_ready, 1'b0);
                    chk("busy_rsp_valid", rsp_valid, 1'b0);
                    chk("busy_alu_sel", alu_G_sel, m_op);
                    chk("busy_alu_ab", {alu_A, alu_B}, pass_drive(m_pass, m_op, m_a, m_b));
                end
                default: begin
                    chk("done_req_ready", req_ready, 1'b0);
                    chk("done_rsp_valid", rsp_valid, 1'b1);
                    chk("done_result", rsp_result, m_exp.res);
                    chk("done_flags", rsp_flags, m_exp.flags);
                    chk("done_err", rsp_err, m_exp.err);
                    chk("done_alu_sel", alu_G_sel, 4'd0);
                    chk("done_alu_ab", {alu_A, alu_B}, 64'd0);
                end
            endcase

            if (reset) begin
                m_state = M_IDLE;
                m_clear = 1'b1;
            end else begin
                case (m_state)
                    M_IDLE: if (req_valid) begin
                        m_op    = req_op;
                        m_a     = req_a;
                        m_b     = req_b;
                        m_exp   = ref_model(req_op, req_wide, req_a, req_b);
                        m_pass  = 1;
                        m_clear = 1'b0;
                        m_state = (m_exp.lat == 3'd1) ? M_DONE : M_BUSY;
                    end
                    M_BUSY: begin
                        m_pass++;
                        if (m_pass == int'(m_exp.lat)) m_state = M_DONE;
                    end
                    default: if (rsp_ready) m_state = M_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic run_cmd(input logic [3:0] op, input logic wide, input logic [63:0] a,
                           input logic [63:0] b, input int hold, output int lat,
                           output logic [63:0] res, output logic [3:0] fl, output logic err);
        logic ok;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_wide  = wide;
        req_a     = a;
        req_b     = b;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_wide  = 1'($urandom);
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("response_timeout", 64'd0, 64'd1);
        res = rsp_result;
        fl  = rsp_flags;
        err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_req_ready", req_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [3:0]  fl;
        logic        err;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [3:0]  rop;
        logic [3:0]  ops [0:4];

        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b1000;
        ops[3] = 4'b1100; ops[4] = 4'b1110;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_wide  = 1'b0;
        req_a     = 64'd0;
        req_b     = 64'd0;
        rsp_ready = 1'b0;

        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_result", rsp_result, 64'd0);
        chk("reset_flags_err", {rsp_flags, rsp_err}, 5'd0);
        chk("reset_alu", {alu_G_sel, alu_A}, 36'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1'b1);

        // Directed cases with hand-computed results
        run_cmd(4'b0000, 1'b0, 64'hABCD0000_7FFFFFFF, 64'h12340000_00000001, 0, lat, res, fl, err);
        chk("nadd_lat", lat, 2);
        chk("nadd_res", res, 64'h00000000_80000000);
        chk("nadd_flags", fl, 4'b0011);

        run_cmd(4'b0000, 1'b1, 64'h00000000_FFFFFFFF, 64'd1, 0, lat, res, fl, err);
        chk("wadd_lat", lat, 4);
        chk("wadd_res", res, 64'h00000001_00000000);
        chk("wadd_flags", fl, 4'b0000);

        run_cmd(4'b0001, 1'b1, 64'h00000001_00000000, 64'd1, 0, lat, res, fl, err);
        chk("wsub_lat", lat, 4);
        chk("wsub_res", res, 64'h00000000_FFFFFFFF);
        chk("wsub_flags", fl, 4'b0100);

        run_cmd(4'b0001, 1'b1, 64'd0, 64'd1, 0, lat, res, fl, err);
        chk("wsub0_res", res, 64'hFFFFFFFF_FFFFFFFF);
        chk("wsub0_flags", fl, 4'b0010);

        run_cmd(4'b0000, 1'b1, 64'h80000000_FFFFFFFF, 64'hFFFFFFFF_00000001, 0, lat, res, fl, err);
        chk("wovf_res", res, 64'h80000000_00000000);
        chk("wovf_flags", fl, 4'b0110);

        run_cmd(4'b1000, 1'b1, 64'h5A5A1234_DEADBEEF, 64'h5A5A1234_DEADBEEF, 0, lat, res, fl, err);
        chk("wxor_lat", lat, 3);
        chk("wxor_res", res, 64'd0);
        chk("wxor_flags", fl, 4'b1000);

        run_cmd(4'b0101, 1'b1, 64'h1, 64'h2, 0, lat, res, fl, err);
        chk("illegal_lat", lat, 1);
        chk("illegal_res", res, 64'd0);
        chk("illegal_flags_err", {fl, err}, 5'b00001);

        run_cmd(4'b0001, 1'b0, 64'd5, 64'd7, 5, lat, res, fl, err);
        chk("bp_lat", lat, 2);
        chk("bp_res", res, 64'h00000000_FFFFFFFE);
        chk("bp_flags", fl, 4'b0010);

        // Reset pulse while the high pass is being driven
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 4'b0000;
        req_wide  = 1'b1;
        req_a     = 64'h00000000_FFFFFFFF;
        req_b     = 64'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_hi_sel", alu_B, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_result", rsp_result, 64'd0);
        chk("abort_alu_sel", alu_G_sel, 4'd0);

        run_cmd(4'b1100, 1'b1, 64'hF0000000_0000000F, 64'h0F000000_000000F0, 1, lat, res, fl, err);
        chk("after_abort_res", res, 64'hFF000000_000000FF);
        chk("after_abort_flags", fl, 4'b0010);

        // Randomized commands; the compare process checks every cycle
        for (int n = 0; n < 300; n++) begin
            rop = ($urandom_range(0, 11) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra[31:0] = 32'hFFFFFFFF;
                1: rb[31:0] = 32'd0;
                2: ra[63:32] = 32'h7FFFFFFF;
                3: rb = ra;
                default: ;
            endcase
            run_cmd(rop, 1'($urandom), ra, rb, $urandom_range(0, 3), lat, res, fl, err);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
